// File: rtl/div_seq_16b_if.sv
// Start/done handshake bundle between the ALU and the sequential divider.
// The master issues operands and start; the slave reports busy, done and results.
interface div_seq_16b_if #(
    parameter int N = 16
);
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_by_zero
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_by_zero
    );
endinterface

// File: rtl/div_seq_16b.sv
// Sequential unsigned restoring divider: one trial subtraction and one quotient bit per cycle,
// fixed N-cycle latency from the accepting edge to the done pulse.
module div_seq_16b #(
    parameter int N = 16
) (
    input  logic          clk,
    input  logic          rst,
    div_seq_16b_if.slave  bus
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic [N-1:0] q_reg;
    logic [N-1:0] q_nxt;
    logic [N-1:0] d_reg;
    logic [N-1:0] d_nxt;
    logic [N-1:0] r_reg;
    logic [N-1:0] r_nxt;
    logic         busy_reg;
    logic         busy_nxt;
    logic         done_reg;
    logic         done_nxt;
    logic [N-1:0] quot_reg;
    logic [N-1:0] quot_nxt;
    logic [N-1:0] rem_reg;
    logic [N-1:0] rem_nxt;
    logic         dbz_reg;
    logic         dbz_nxt;

    logic [N:0]   trial;
    logic [N:0]   diff;
    logic [N-1:0] q_shift;
    logic [N-1:0] r_step;
    logic         last_iter;

    // The partial remainder always stays below the divisor (or is a prefix of the
    // dividend when dividing by zero), so N bits of R are enough to hold it.
    assign trial     = {r_reg, q_reg[N-1]};
    assign diff      = trial + ~{1'b0, d_reg} + {{N{1'b0}}, 1'b1};
    assign q_shift   = {q_reg[N-2:0], ~diff[N]};
    assign r_step    = diff[N] ? trial[N-1:0] : diff[N-1:0];
    assign last_iter = (cnt == CW'(N - 1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        q_nxt     = q_reg;
        d_nxt     = d_reg;
        r_nxt     = r_reg;
        busy_nxt  = busy_reg;
        done_nxt  = 1'b0;
        quot_nxt  = quot_reg;
        rem_nxt   = rem_reg;
        dbz_nxt   = dbz_reg;

        case (state)
            IDLE: begin
                if (bus.start) begin
                    q_nxt     = bus.dividend;
                    d_nxt     = bus.divisor;
                    r_nxt     = '0;
                    cnt_nxt   = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                q_nxt   = q_shift;
                r_nxt   = r_step;
                cnt_nxt = cnt + CW'(1);
                if (last_iter) begin
                    quot_nxt  = q_shift;
                    rem_nxt   = r_step;
                    dbz_nxt   = (d_reg == '0);
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            q_reg    <= '0;
            d_reg    <= '0;
            r_reg    <= '0;
            busy_reg <= 1'b0;
            done_reg <= 1'b0;
            quot_reg <= '0;
            rem_reg  <= '0;
            dbz_reg  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            q_reg    <= q_nxt;
            d_reg    <= d_nxt;
            r_reg    <= r_nxt;
            busy_reg <= busy_nxt;
            done_reg <= done_nxt;
            quot_reg <= quot_nxt;
            rem_reg  <= rem_nxt;
            dbz_reg  <= dbz_nxt;
        end
    end

    assign bus.busy        = busy_reg;
    assign bus.done        = done_reg;
    assign bus.quotient    = quot_reg;
    assign bus.remainder   = rem_reg;
    assign bus.div_by_zero = dbz_reg;
endmodule
